dpll_search_ctrl: RTL and testbench

- Sequential DPLL search controller that sits directly downstream of the combinational clause evaluator (sat_check).
- Owns the variable assignment and drives it to the evaluator; the evaluator's simplified clauses feed sat_check.
- Consumes sat_check's return_true / return_false to decide, flip or backtrack.
- Runs chronological-backtracking DPLL (decide plus backtrack; no unit propagation) until SAT or UNSAT, then reports the result and the model.

---
 rtl/dpll_search_ctrl_pkg.sv | 32 +++
 rtl/dpll_first_unassigned.sv | 22 ++
 rtl/dpll_search_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dpll_search_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpll_search_ctrl_pkg.sv
// Shared definitions for the DPLL search controller: state encoding,
// trail entry field widths and a constant-time clog2 helper.
package dpll_search_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EVAL      = 3'd1,
    ST_DECIDE    = 3'd2,
    ST_BACKTRACK = 3'd3,
    ST_SAT       = 3'd4,
    ST_UNSAT     = 3'd5
  } state_t;

  localparam int TRAIL_FLIP_W = 1;
  localparam int MAX_VARS     = 32;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      r = ((32'd1 << i) < value) ? (i + 1) : r;
    end
    return r;
  endfunction

  // Trail variable-index field width for a given variable count.
  function automatic int idx_width_f(input int n_vars);
    return (n_vars > 1) ? clog2_f(n_vars) : 1;
  endfunction

endpackage

// File: rtl/dpll_first_unassigned.sv
// Priority encoder: index of the lowest-numbered variable whose mask bit is
// clear, plus a flag saying whether any such variable exists.
module dpll_first_unassigned #(
  parameter int N_VARS = 8,
  parameter int IDX_W  = 3
) (
  input  logic [N_VARS-1:0] assign_mask,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  // Scan high to low so the lowest free index is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N_VARS - 1; i >= 0; i--) begin
      idx   = assign_mask[i] ? idx : IDX_W'(i);
      found = found | ~assign_mask[i];
    end
  end

endmodule

// File: rtl/dpll_search_ctrl.sv
// Chronological-backtracking DPLL controller: owns the assignment fed to the
// clause evaluator and steps decide / flip / pop until SAT or UNSAT.
module dpll_search_ctrl
  import dpll_search_ctrl_pkg::*;
#(
  parameter int   N_VARS  = 8,
  parameter logic DEF_POL = 1'b0,
  parameter int   CNT_W   = 16,
  localparam int  IDX_W   = idx_width_f(N_VARS),
  localparam int  DEPTH_W = clog2_f(N_VARS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               return_true,
  input  logic               return_false,
  output logic [N_VARS-1:0]  assign_val,
  output logic [N_VARS-1:0]  assign_mask,
  output logic               busy,
  output logic               done,
  output logic               sat,
  output logic [DEPTH_W-1:0] depth,
  output logic [CNT_W-1:0]   n_decisions,
  output logic [CNT_W-1:0]   n_conflicts
);

  state_t             state_r;
  logic [N_VARS-1:0]  assign_val_r;
  logic [N_VARS-1:0]  assign_mask_r;
  logic               busy_r;
  logic               done_r;
  logic               sat_r;
  logic [DEPTH_W-1:0] depth_r;
  logic [CNT_W-1:0]   n_decisions_r;
  logic [CNT_W-1:0]   n_conflicts_r;

  logic [IDX_W-1:0]        trail_var_r  [N_VARS];
  logic [TRAIL_FLIP_W-1:0] trail_flip_r [N_VARS];

  logic [IDX_W-1:0] first_idx_s;
  logic             found_s;
  logic [IDX_W-1:0] push_ptr_s;
  logic [IDX_W-1:0] top_ptr_s;
  logic [IDX_W-1:0] top_var_s;
  logic             top_flip_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_W'(1));
  endfunction

  dpll_first_unassigned #(
    .N_VARS (N_VARS),
    .IDX_W  (IDX_W)
  ) u_first_unassigned (
    .assign_mask (assign_mask_r),
    .idx         (first_idx_s),
    .found       (found_s)
  );

  // Trail stack pointers; top is only dereferenced when depth is non-zero.
  always_comb begin
    push_ptr_s = IDX_W'(depth_r);
    top_ptr_s  = IDX_W'(depth_r - DEPTH_W'(1));
    top_var_s  = trail_var_r[top_ptr_s];
    top_flip_s = trail_flip_r[top_ptr_s][0];
  end

  // Search FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      assign_val_r  <= '0;
      assign_mask_r <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      sat_r         <= 1'b0;
      depth_r       <= '0;
      n_decisions_r <= '0;
      n_conflicts_r <= '0;
      for (int i = 0; i < N_VARS; i++) begin
        trail_var_r[i]  <= '0;
        trail_flip_r[i] <= '0;
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_SAT, ST_UNSAT: begin
          if (start) begin
            assign_val_r  <= '0;
            assign_mask_r <= '0;
            depth_r       <= '0;
            n_decisions_r <= '0;
            n_conflicts_r <= '0;
            sat_r         <= 1'b0;
            busy_r        <= 1'b1;
            state_r       <= ST_EVAL;
          end else begin
            state_r <= state_r;
          end
        end
        ST_EVAL: begin
          if (return_true) begin
            sat_r   <= 1'b1;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_SAT;
          end else if (return_false) begin
            n_conflicts_r <= sat_inc(n_conflicts_r);
            state_r       <= ST_BACKTRACK;
          end else begin
            state_r <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          if (found_s) begin
            assign_mask_r[first_idx_s] <= 1'b1;
            assign_val_r[first_idx_s]  <= DEF_POL;
            trail_var_r[push_ptr_s]    <= first_idx_s;
            trail_flip_r[push_ptr_s]   <= '0;
            depth_r                    <= depth_r + DEPTH_W'(1);
            n_decisions_r              <= sat_inc(n_decisions_r);
            state_r                    <= ST_EVAL;
          end else begin
            // Full assignment that is neither satisfied nor falsified.
            n_conflicts_r <= sat_inc(n_conflicts_r);
            state_r       <= ST_BACKTRACK;
          end
        end
        ST_BACKTRACK: begin
          if (depth_r == DEPTH_W'(0)) begin
            assign_val_r  <= '0;
            assign_mask_r <= '0;
            sat_r         <= 1'b0;
            done_r        <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= ST_UNSAT;
          end else if (!top_flip_s) begin
            assign_val_r[top_var_s] <= ~assign_val_r[top_var_s];
            trail_flip_r[top_ptr_s] <= 1'b1;
            state_r                 <= ST_EVAL;
          end else begin
            assign_mask_r[top_var_s] <= 1'b0;
            assign_val_r[top_var_s]  <= 1'b0;
            depth_r                  <= depth_r - DEPTH_W'(1);
            state_r                  <= ST_BACKTRACK;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign assign_val  = assign_val_r;
  assign assign_mask = assign_mask_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign sat         = sat_r;
  assign depth       = depth_r;
  assign n_decisions = n_decisions_r;
  assign n_conflicts = n_conflicts_r;

endmodule

// File: tb/tb_dpll_search_ctrl.sv
// Bench for dpll_search_ctrl: a combinational CNF evaluator model drives the
// DUT, table vectors go through a scoreboard queue, corner cases are hand-run.
module tb_dpll_search_ctrl;

  typedef struct {
    string      name;
    logic [15:0] pos;
    logic [15:0] neg;
    int          n_cl;
    logic        force_both;
    logic        exp_sat;
    logic [3:0]  exp_mask;
    logic [3:0]  exp_val;
    int          exp_dec;
    int          exp_conf;
    int          exp_depth;
    int          exp_lat;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start2;
  logic        return_true, return_false;
  logic        return_true2, return_false2;
  logic [3:0]  assign_val, assign_mask, assign_val2, assign_mask2;
  logic        busy, done, sat, busy2, done2, sat2;
  logic [2:0]  depth, depth2;
  logic [15:0] n_decisions, n_conflicts;
  logic [1:0]  n_decisions2, n_conflicts2;

  logic [15:0] cnf_pos, cnf_neg;
  int          cnf_n;
  logic        force_both;

  int checks;
  int failures;
  vec_t tbl[6];
  vec_t sb_q[$];

  dpll_search_ctrl #(.N_VARS(4), .DEF_POL(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .return_true(return_true), .return_false(return_false),
    .assign_val(assign_val), .assign_mask(assign_mask),
    .busy(busy), .done(done), .sat(sat), .depth(depth),
    .n_decisions(n_decisions), .n_conflicts(n_conflicts)
  );

  dpll_search_ctrl #(.N_VARS(4), .DEF_POL(1'b0), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .start(start2),
    .return_true(return_true2), .return_false(return_false2),
    .assign_val(assign_val2), .assign_mask(assign_mask2),
    .busy(busy2), .done(done2), .sat(sat2), .depth(depth2),
    .n_decisions(n_decisions2), .n_conflicts(n_conflicts2)
  );

  // Returns {all clauses satisfied, some clause falsified}.
  function automatic logic [1:0] eval_cnf(input logic [15:0] pos, input logic [15:0] neg,
                                          input int n_cl, input logic [3:0] m, input logic [3:0] v);
    logic all_sat, any_false, sat_c;
    logic [3:0] p, n;
    all_sat = 1'b1;
    any_false = 1'b0;
    for (int k = 0; k < n_cl; k++) begin
      p = pos[4*k +: 4];
      n = neg[4*k +: 4];
      sat_c = |((p & m & v) | (n & m & ~v));
      all_sat = all_sat & sat_c;
      any_false = any_false | ((((p | n) & ~m) == 4'b0000) && !sat_c);
    end
    return {all_sat, any_false};
  endfunction

  always_comb begin
    logic [1:0] r1, r2;
    r1 = eval_cnf(cnf_pos, cnf_neg, cnf_n, assign_mask, assign_val);
    r2 = eval_cnf(cnf_pos, cnf_neg, cnf_n, assign_mask2, assign_val2);
    return_true   = r1[1] | force_both;
    return_false  = r1[0] | force_both;
    return_true2  = r2[1];
    return_false2 = r2[0];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    vec_t e;
    int   cyc;
    logic got;
    cnf_pos = t.pos;
    cnf_neg = t.neg;
    cnf_n = t.n_cl;
    force_both = t.force_both;
    sb_q.push_back(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    got = done;
    chk({t.name, " busy_after_start"}, 64'(busy | done), 64'd1);
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      got = done;
    end
    chk({t.name, " done_seen"}, 64'(got), 64'd1);
    e = sb_q.pop_front();
    if (e.exp_lat != 0) chk({e.name, " latency"}, 64'(cyc), 64'(e.exp_lat));
    chk({e.name, " sat"}, 64'(sat), 64'(e.exp_sat));
    chk({e.name, " mask"}, 64'(assign_mask), 64'(e.exp_mask));
    chk({e.name, " val"}, 64'(assign_val), 64'(e.exp_val));
    chk({e.name, " n_decisions"}, 64'(n_decisions), 64'(e.exp_dec));
    chk({e.name, " n_conflicts"}, 64'(n_conflicts), 64'(e.exp_conf));
    chk({e.name, " depth"}, 64'(depth), 64'(e.exp_depth));
    chk({e.name, " busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({e.name, " done_pulse_once"}, 64'(done), 64'd0);
    chk({e.name, " mask_held"}, 64'(assign_mask), 64'(e.exp_mask));
    chk({e.name, " sat_held"}, 64'(sat), 64'(e.exp_sat));
    force_both = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic got;
    logic seen_done;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    force_both = 1'b0;
    cnf_pos = 16'h0000;
    cnf_neg = 16'h0000;
    cnf_n = 0;

    //          name        pos       neg       n  frc  sat   mask     val      dec conf dep lat
    tbl[0] = '{"empty",     16'h0000, 16'h0000, 0, 1'b0, 1'b1, 4'b0000, 4'b0000, 0, 0, 0, 2};
    tbl[1] = '{"x0_nx0",    16'h0001, 16'h0010, 2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1, 2, 0, 0};
    tbl[2] = '{"imp_x2",    16'h0042, 16'h0001, 2, 1'b0, 1'b1, 4'b0111, 4'b0100, 3, 1, 3, 0};
    tbl[3] = '{"or_nx0",    16'h0003, 16'h0010, 2, 1'b0, 1'b1, 4'b0011, 4'b0010, 2, 1, 2, 0};
    tbl[4] = '{"x3_full",   16'h0008, 16'h0000, 1, 1'b0, 1'b1, 4'b1111, 4'b1000, 4, 1, 4, 0};
    tbl[5] = '{"both_high", 16'h0001, 16'h0010, 2, 1'b1, 1'b1, 4'b0000, 4'b0000, 0, 0, 0, 2};

    repeat (2) @(negedge clk);
    chk("reset mask", 64'(assign_mask), 64'd0);
    chk("reset val", 64'(assign_val), 64'd0);
    chk("reset flags", 64'({busy, done, sat}), 64'd0);
    chk("reset depth", 64'(depth), 64'd0);
    chk("reset counters", 64'({n_decisions, n_conflicts}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Start pulsed while busy, then reset in BACKTRACK on (x0)(~x0).
    cnf_pos = 16'h0001;
    cnf_neg = 16'h0010;
    cnf_n = 2;
    seen_done = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = seen_done | done;
    repeat (2) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = seen_done | done;
    chk("busy_start n_decisions", 64'(n_decisions), 64'd1);
    chk("busy_start n_conflicts", 64'(n_conflicts), 64'd1);
    chk("busy_start mask", 64'(assign_mask), 64'd1);
    chk("busy_start busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst mask", 64'(assign_mask), 64'd0);
    chk("midrst val", 64'(assign_val), 64'd0);
    chk("midrst flags", 64'({busy, done, sat}), 64'd0);
    chk("midrst depth", 64'(depth), 64'd0);
    chk("midrst counters", 64'({n_decisions, n_conflicts}), 64'd0);
    repeat (2) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    rst = 1'b0;
    @(negedge clk);
    seen_done = seen_done | done;
    chk("midrst no_done", 64'(seen_done), 64'd0);
    run_vec(tbl[2]);

    // Saturating counters on the narrow instance: (x3)(~x3) is UNSAT.
    cnf_pos = 16'h0008;
    cnf_neg = 16'h0080;
    cnf_n = 2;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    got = done2;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      got = done2;
    end
    chk("sat_cnt done_seen", 64'(got), 64'd1);
    chk("sat_cnt sat", 64'(sat2), 64'd0);
    chk("sat_cnt n_conflicts", 64'(n_conflicts2), 64'd3);
    chk("sat_cnt n_decisions", 64'(n_decisions2), 64'd3);
    chk("sat_cnt mask", 64'(assign_mask2), 64'd0);
    chk("sat_cnt depth", 64'(depth2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
